// File: rtl/axis_write_data.sv
// AXI write-data channel driver: buffers a narrow word stream in a FIFO, packs
// WIDTH_RATIO words per beat and marks burst/transfer ends with wlast.
module axis_write_data #(
  parameter int BUF_AWIDTH     = 9,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CONFIG_DWIDTH-1:0]    cfg_length,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready
);

  localparam int DEPTH  = 1 << BUF_AWIDTH;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int LSTRB  = DATA_WIDTH / 8;
  localparam int LANE_W = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam int BPOS_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACTIVE = 3'b010,
    DONE   = 3'b100
  } state_t;

  state_t                     state_q, state_d;
  logic [CONFIG_DWIDTH-1:0]   len_q, wcnt_q, pcnt_q;
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [BUF_AWIDTH:0]        wptr_q, rptr_q;
  logic [LANE_W-1:0]          lane_q;
  logic [AXI_DATA_WIDTH-1:0]  pack_q, wdata_q, beat_data;
  logic [STRB_W-1:0]          wstrb_q, beat_strb;
  logic [BPOS_W-1:0]          bpos_q;
  logic                       wlast_q, wvalid_q, final_q;
  logic                       fifo_empty, fifo_full, push, pop, out_free;
  logic                       beat_end, last_word, burst_end;
  logic [DATA_WIDTH-1:0]      head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[BUF_AWIDTH] != rptr_q[BUF_AWIDTH]) &&
                      (wptr_q[BUF_AWIDTH-1:0] == rptr_q[BUF_AWIDTH-1:0]);
  assign cfg_ready  = (state_q == IDLE);
  assign ready      = (state_q == ACTIVE) && !fifo_full && (wcnt_q < len_q);
  assign push       = valid && ready;
  assign head       = mem[rptr_q[BUF_AWIDTH-1:0]];

  assign last_word  = (pcnt_q == len_q - CONFIG_DWIDTH'(1));
  assign beat_end   = (lane_q == LANE_W'(WIDTH_RATIO - 1)) || last_word;
  assign burst_end  = (bpos_q == BPOS_W'(BURST_LEN - 1));
  // A beat-completing pop needs the output register free (or draining this cycle).
  assign out_free   = !wvalid_q || axi_wready;
  assign pop        = (state_q == ACTIVE) && !fifo_empty && (!beat_end || out_free);

  always_comb begin
    beat_data = pack_q | (AXI_DATA_WIDTH'(head) << (DATA_WIDTH * int'(lane_q)));
    beat_strb = '0;
    for (int k = 0; k < WIDTH_RATIO; k++) begin
      if (k <= int'(lane_q)) beat_strb[k*LSTRB +: LSTRB] = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_valid) state_d = (cfg_length == '0) ? DONE : ACTIVE;
      ACTIVE:  if (wvalid_q && axi_wready && final_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 0: FIFO write
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[BUF_AWIDTH-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wcnt_q   <= '0;
      pcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      lane_q   <= '0;
      pack_q   <= '0;
      bpos_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      wvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (cfg_valid) len_q <= cfg_length;
        wcnt_q <= '0;
        pcnt_q <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        lane_q <= '0;
        pack_q <= '0;
        bpos_q <= '0;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + 1'b1;
          wcnt_q <= wcnt_q + 1'b1;
        end
        // Stage 1: pack register collects lanes of the beat in progress
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
          pcnt_q <= pcnt_q + 1'b1;
          if (beat_end) begin
            lane_q <= '0;
            pack_q <= '0;
            bpos_q <= burst_end ? '0 : bpos_q + 1'b1;
          end else begin
            lane_q <= lane_q + 1'b1;
            pack_q <= beat_data;
          end
        end
      end
      // Stage 2: AXI output register, reloaded in the handshake cycle when possible
      if (pop && beat_end) begin
        wdata_q  <= beat_data;
        wstrb_q  <= beat_strb;
        wlast_q  <= burst_end || last_word;
        final_q  <= last_word;
        wvalid_q <= 1'b1;
      end else if (axi_wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_wlast  = wlast_q;
  assign axi_wvalid = wvalid_q;

endmodule

// File: tb/tb_axis_write_data.sv
// Scoreboard bench for axis_write_data: expected beats are derived from the
// word list and pushed at configuration time; a monitor pops them on handshakes.
module tb_axis_write_data;
  localparam int DW = 32;
  localparam int R  = 2;
  localparam int AW = 64;
  localparam int SW = AW / 8;
  localparam int BL = 16;
  localparam int CW = 32;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg_length = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [AW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready = 1'b0;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int wmode = 0;
  int hold_until = 0;
  logic [DW-1:0] words[$];
  beat_t         exp_q[$];
  beat_t         mon_e;
  logic          pend = 1'b0;
  logic [127:0]  held = '0;

  always #5 clk = ~clk;

  axis_write_data dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_length (cfg_length),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wlast  (axi_wlast),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave ready: 0 = always ready, 1 = random, 2 = held low until hold_until
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (wmode)
      0:       axi_wready = 1'b1;
      1:       axi_wready = 1'($urandom_range(0, 1));
      default: axi_wready = (cyc >= hold_until);
    endcase
  end

  // Monitor: compares each handshaken beat with the scoreboard and checks hold stability
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) chk("hold_stable", {axi_wvalid, axi_wlast, axi_wstrb, axi_wdata}, held);
      if (axi_wvalid && axi_wready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got wdata 0x%0h, no beat expected", axi_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", axi_wdata, mon_e.d);
          chk("beat_strb", axi_wstrb, mon_e.s);
          chk("beat_last", axi_wlast, mon_e.l);
        end
      end
      pend = axi_wvalid && !axi_wready;
      held = {axi_wvalid, axi_wlast, axi_wstrb, axi_wdata};
    end
  end

  // Reference model: beat b carries words b*R .. b*R+R-1, missing words are zero lanes
  task automatic gen_xfer(input int len, input bit seq);
    int nb;
    words.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) words.push_back(seq ? DW'(i + 1) : DW'($urandom));
    nb = (len + R - 1) / R;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e = '0;
      for (int k = 0; k < R; k++) begin
        if (b * R + k < len) begin
          e.d[k*DW +: DW]     = words[b * R + k];
          e.s[k*(DW/8) +: DW/8] = '1;
        end
      end
      e.l = ((b % BL) == BL - 1) || (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start(input int len);
    beats_seen = 0;
    @(posedge clk); #1;
    cfg_length = CW'(len);
    cfg_valid  = 1'b1;
    @(negedge clk); #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int stop_beats, input bit rnd);
    int guard = 0;
    acc_cnt = 0;
    while (acc_cnt < n) begin
      if (stop_beats > 0 && beats_seen >= stop_beats) return;
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: accepted %0d words, required %0d", acc_cnt, n);
        valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data  = words[acc_cnt];
      @(negedge clk); #1;
      if (valid && ready) acc_cnt++;
      guard++;
    end
    @(posedge clk); #1;
    valid = 1'b1;
    data  = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    chk("ready_after_last", ready, 0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic finish_xfer();
    int g = 0;
    while (exp_q.size() != 0 && g < 20000) begin
      @(negedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
      return;
    end
    @(negedge clk); #1;
    chk("cfg_ready_done", cfg_ready, 0);
    @(negedge clk); #1;
    chk("cfg_ready_back", cfg_ready, 1);
    chk("wvalid_idle", axi_wvalid, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_ready", ready, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_wlast", axi_wlast, 0);
    chk("rst_wdata", axi_wdata, 0);
    chk("rst_wstrb", axi_wstrb, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential data, full-rate slave
    wmode = 0;
    gen_xfer(8, 1); start(8); feed(8, 0, 0); finish_xfer();
    chk("t1_beats", beats_seen, 4);

    // Odd length: partial last beat
    wmode = 1;
    gen_xfer(5, 0); start(5); feed(5, 0, 0); finish_xfer();
    chk("t2_beats", beats_seen, 3);

    // Burst boundary inside a transfer
    wmode = 0;
    gen_xfer(40, 0); start(40); feed(40, 0, 1); finish_xfer();
    chk("t3_beats", beats_seen, 20);

    // Long stall with continuous input
    wmode = 2;
    hold_until = cyc + 600;
    gen_xfer(1024, 0); start(1024);
    fork
      feed(1024, 0, 0);
      begin
        repeat (560) @(negedge clk);
        #1;
        chk("stall_ready", ready, 0);
        chk("stall_wvalid", axi_wvalid, 1);
        chk("stall_fill", (acc_cnt >= 512 && acc_cnt < 1024), 1);
      end
    join
    finish_xfer();
    chk("t4_beats", beats_seen, 512);
    wmode = 0;

    // Zero length
    gen_xfer(0, 0); start(0);
    @(negedge clk); #1;
    chk("len0_cfg_ready_low", cfg_ready, 0);
    chk("len0_wvalid", axi_wvalid, 0);
    @(negedge clk); #1;
    chk("len0_cfg_ready_high", cfg_ready, 1);
    chk("len0_beats", beats_seen, 0);

    // Reset during beat 3 of 10, then a clean short transfer
    gen_xfer(20, 0); start(20); feed(20, 3, 0);
    @(posedge clk); #1;
    rst   = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    chk("mid_rst_wvalid", axi_wvalid, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    gen_xfer(4, 0); start(4); feed(4, 0, 0); finish_xfer();
    chk("post_rst_beats", beats_seen, 2);

    // Random lengths with random stream and slave timing
    wmode = 1;
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 45);
      gen_xfer(len, 0); start(len); feed(len, 0, 1); finish_xfer();
      chk("rand_beats", beats_seen, (len + R - 1) / R);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
